irq_timer: RTL and testbench

//   Memory-mapped interval timer that generates the IRQ line consumed by the CPU control/decode stage.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/irq_timer_tick_gen.sv | 43 ++++
 rtl/irq_timer.sv | 126 ++++++++++++
 tb/tb_irq_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register
// offsets, TCON bit positions and the register-select encoding.
package timer_pkg;

    localparam logic [31:0] OFF_TH   = 32'd0;
    localparam logic [31:0] OFF_TL   = 32'd4;
    localparam logic [31:0] OFF_TCON = 32'd8;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;

    typedef enum logic [1:0] {
        SEL_TH   = 2'd0,
        SEL_TL   = 2'd1,
        SEL_TCON = 2'd2,
        SEL_NONE = 2'd3
    } reg_sel_e;

    // Map a word-aligned byte address onto one of the timer registers.
    function automatic reg_sel_e decode_sel(input logic [31:0] word_addr,
                                            input logic [31:0] base);
        reg_sel_e sel;
        if (word_addr == base + OFF_TH) begin
            sel = SEL_TH;
        end else if (word_addr == base + OFF_TL) begin
            sel = SEL_TL;
        end else if (word_addr == base + OFF_TCON) begin
            sel = SEL_TCON;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/irq_timer_tick_gen.sv
// Prescaler: produces a one-cycle tick every PRESCALE enabled clocks.
// The count is held at zero while disabled so a re-enable always starts a
// full period. With PRESCALE=1 the counter stays at zero and reduces to a
// constant, making tick follow en directly.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next prescale count: cleared when disabled or on wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescale counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/irq_timer.sv
// Memory-mapped interval timer on the data-memory bus. TH holds the reload
// value, TL is the up-counter and TCON holds enable / interrupt-enable /
// sticky status. irq is a level derived only from registered TCON bits.
module irq_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;

    logic [31:0] word_addr_s;
    reg_sel_e    sel_s;
    logic        wr_th_s, wr_tl_s, wr_tcon_s;
    logic        en_next_s;
    logic        tick_s;
    logic        overflow_s;

    assign word_addr_s = mem_addr & 32'hFFFF_FFFC;

    // Address decode and per-register write strobes.
    always_comb begin
        sel_s     = decode_sel(word_addr_s, BASE_ADDR);
        hit       = (sel_s != SEL_NONE);
        wr_th_s   = mem_write && (sel_s == SEL_TH);
        wr_tl_s   = mem_write && (sel_s == SEL_TL);
        wr_tcon_s = mem_write && (sel_s == SEL_TCON);
    end

    // A same-cycle TCON write decides whether this edge may tick, so a
    // clear of the enable suppresses the tick it coincides with.
    assign en_next_s = wr_tcon_s ? mem_wdata[TCON_EN] : tcon_q[TCON_EN];

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en_next_s),
        .tick  (tick_s)
    );

    // A software write to TL takes priority, so it also cancels an overflow.
    assign overflow_s = tick_s && !wr_tl_s && (tl_q == 32'hFFFF_FFFF);

    // Next-state for TH, TL and TCON including simultaneous-event priority.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (wr_th_s) begin
            th_d = mem_wdata;
        end else begin
            th_d = th_q;
        end

        // Reload uses th_q, i.e. the old TH even if TH is written this cycle.
        if (wr_tl_s) begin
            tl_d = mem_wdata;
        end else if (overflow_s) begin
            tl_d = th_q;
        end else if (tick_s) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end

        if (wr_tcon_s) begin
            tcon_d = mem_wdata[2:0];
        end else begin
            tcon_d = tcon_q;
        end

        // Status set beats a software clear on the same edge.
        if (overflow_s && tcon_q[TCON_IE]) begin
            tcon_d[TCON_ST] = 1'b1;
        end else begin
            tcon_d[TCON_ST] = tcon_d[TCON_ST];
        end
    end

    // Timer register file with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Zero-wait-state read mux; drives zero unless a read hits the timer.
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_read) begin
            case (sel_s)
                SEL_TH:   mem_rdata = th_q;
                SEL_TL:   mem_rdata = tl_q;
                SEL_TCON: mem_rdata = {29'd0, tcon_q};
                default:  mem_rdata = 32'd0;
            endcase
        end else begin
            mem_rdata = 32'd0;
        end
    end

    assign irq = tcon_q[TCON_ST] & tcon_q[TCON_IE];

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: a vector table for decode/read/write and
// hand-written sequences for overflow, priority and prescaler behaviour.
module tb_irq_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rdata1, rdata4;
    logic        hit1, hit4;
    logic        irq1, irq4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    irq_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(rdata1),
        .hit(hit1), .irq(irq1)
    );

    irq_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(rdata4),
        .hit(hit4), .irq(irq4)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic chk_reg(input string nm, input logic [31:0] a,
                           input logic use4, input logic [31:0] exp);
        mem_addr = a;
        mem_read = 1'b1;
        #1;
        if (use4) chk(nm, rdata4, exp);
        else      chk(nm, rdata1, exp);
        mem_read = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_write = 1'b0;
        mem_read  = 1'b0;

        //           wr    rd    addr                   wdata          rdata          hit   irq
        vecs[0]  = '{1'b0, 1'b1, A_TH,                 32'd0,         32'd0,         1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, A_TL,                 32'd0,         32'd0,         1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, A_TC,                 32'd0,         32'd0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, BASE + 32'd12,        32'd0,         32'd0,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, A_TH,                 32'h1234_5678, 32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, A_TH,                 32'd0,         32'h1234_5678, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, A_TL,                 32'hA5A5_0001, 32'd0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, A_TL,                 32'd0,         32'hA5A5_0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, A_TC,                 32'hFFFF_FFF8, 32'd0,         1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, A_TC,                 32'd0,         32'd0,         1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, A_TC,                 32'd4,         32'd0,         1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, A_TC,                 32'd0,         32'd4,         1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, A_TC,                 32'd6,         32'd0,         1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, BASE + 32'd10,        32'd0,         32'd6,         1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, BASE + 32'd3,         32'd0,         32'h1234_5678, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, BASE - 32'd4,         32'd0,         32'd0,         1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, A_TL,                 32'd0,         32'd0,         1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b0, A_TC,                 32'd0,         32'd0,         1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b1, BASE + 32'h1000_0008, 32'd0,         32'd0,         1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, A_TL,                 32'd0,         32'hA5A5_0001, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, BASE + 32'd12,        32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, A_TC,                 32'd0,         32'd0,         1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Register decode / read / write table (timer disabled throughout).
        for (int i = 0; i < 22; i++) begin
            mem_write = vecs[i].wr;
            mem_read  = vecs[i].rd;
            mem_addr  = vecs[i].addr;
            mem_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d rdata", i), rdata1, vecs[i].exp_rdata);
            chk($sformatf("vec%0d hit", i), {31'd0, hit1}, {31'd0, vecs[i].exp_hit});
            chk($sformatf("vec%0d hit4", i), {31'd0, hit4}, {31'd0, vecs[i].exp_hit});
            chk($sformatf("vec%0d irq", i), {31'd0, irq1}, {31'd0, vecs[i].exp_irq});
            @(posedge clk);
            #1;
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;

        // Overflow with interrupts disabled: reload, no status.
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFC);
        bus_write(A_TC, 32'd1);
        chk_reg("noie TL fd", A_TL, 1'b0, 32'hFFFF_FFFD);
        step();
        chk_reg("noie TL fe", A_TL, 1'b0, 32'hFFFF_FFFE);
        step();
        chk_reg("noie TL ff", A_TL, 1'b0, 32'hFFFF_FFFF);
        step();
        chk_reg("noie TL reload", A_TL, 1'b0, 32'hFFFF_FFFC);
        chk_reg("noie TCON", A_TC, 1'b0, 32'd1);
        chk("noie irq", {31'd0, irq1}, 32'd0);

        // Overflow with interrupts enabled.
        pulse_reset();
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFC);
        bus_write(A_TC, 32'd3);
        chk_reg("ie TL fd", A_TL, 1'b0, 32'hFFFF_FFFD);
        step();
        chk_reg("ie TL fe", A_TL, 1'b0, 32'hFFFF_FFFE);
        step();
        chk_reg("ie TL ff", A_TL, 1'b0, 32'hFFFF_FFFF);
        chk("ie irq before", {31'd0, irq1}, 32'd0);
        step();
        chk_reg("ie TL reload", A_TL, 1'b0, 32'hFFFF_FFFC);
        chk_reg("ie TCON st", A_TC, 1'b0, 32'd7);
        chk("ie irq after", {31'd0, irq1}, 32'd1);

        // Software clear of status drops irq.
        bus_write(A_TC, 32'd3);
        chk("clr irq", {31'd0, irq1}, 32'd0);
        chk_reg("clr TL", A_TL, 1'b0, 32'hFFFF_FFFD);
        step();
        step();
        // Clear timed on the overflow edge: the set wins.
        bus_write(A_TC, 32'd3);
        chk("race irq", {31'd0, irq1}, 32'd1);
        chk_reg("race TCON", A_TC, 1'b0, 32'd7);
        chk_reg("race TL", A_TL, 1'b0, 32'hFFFF_FFFC);

        // TH write on the overflow edge: reload uses old TH.
        step();
        step();
        step();
        chk_reg("th race pre TL", A_TL, 1'b0, 32'hFFFF_FFFF);
        bus_write(A_TH, 32'h0000_0010);
        chk_reg("th race TL", A_TL, 1'b0, 32'hFFFF_FFFC);
        chk_reg("th race TH", A_TH, 1'b0, 32'h0000_0010);

        // TL write while counting: write wins, no increment.
        bus_write(A_TL, 32'd5);
        chk_reg("tl race", A_TL, 1'b0, 32'd5);
        step();
        chk_reg("tl race next", A_TL, 1'b0, 32'd6);

        // Clearing enable suppresses the coincident tick.
        bus_write(A_TC, 32'd6);
        chk_reg("en clr TL", A_TL, 1'b0, 32'd6);
        step();
        chk_reg("en clr frozen", A_TL, 1'b0, 32'd6);
        chk("en clr irq", {31'd0, irq1}, 32'd1);

        // Reset mid-count with irq pending.
        bus_write(A_TC, 32'd7);
        chk_reg("pre rst TL", A_TL, 1'b0, 32'd7);
        pulse_reset();
        chk_reg("rst TL", A_TL, 1'b0, 32'd0);
        chk_reg("rst TH", A_TH, 1'b0, 32'd0);
        chk_reg("rst TCON", A_TC, 1'b0, 32'd0);
        chk("rst irq", {31'd0, irq1}, 32'd0);

        // Prescaler of 4 on the second instance.
        bus_write(A_TC, 32'd1);
        step();
        step();
        chk_reg("ps TL hold", A_TL, 1'b1, 32'd0);
        step();
        chk_reg("ps TL one", A_TL, 1'b1, 32'd1);
        step();
        step();
        bus_write(A_TC, 32'd0);
        repeat (5) step();
        chk_reg("ps frozen", A_TL, 1'b1, 32'd1);
        bus_write(A_TC, 32'd1);
        step();
        step();
        chk_reg("ps restart hold", A_TL, 1'b1, 32'd1);
        step();
        chk_reg("ps restart two", A_TL, 1'b1, 32'd2);
        chk("ps irq", {31'd0, irq4}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
